norm_pipeline_sequencer: RTL and testbench
==========================================

# norm_pipeline_sequencer

Frame-level controller that sequences the crop-filter and normalization stages of the single-camera processing path. On a host `ap_start` it launches the crop filter and waits for its completion. It then latches the normalization denominator and releases the norm stage. It counts the normalized pixels accepted downstream and reports frame completion through an ap_ctrl-style handshake.

## Interface
Parameters:
- `PIXEL_BIT_WIDTH`, 10: pixel and denominator width.
- `PIX_CNT_WIDTH`, 20: width of the frame pixel counter.
- `TIMEOUT_CYCLES`, 1048576: watchdog limit in cycles (used only when the watchdog is compiled in).

Ports (reset is synchronous, active-high; clock is `clk`):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `ap_start`  in  1  host start request, level-sensitive.
- `ap_done`  out  1  one-cycle pulse when the frame completes.
- `ap_idle`  out  1  high while in IDLE.
- `ap_ready`  out  1  one-cycle pulse when the start is accepted.
- `frame_pixels`  in  PIX_CNT_WIDTH  number of output pixels expected; sampled on start.
- `cf_ap_start`  out  1  one-cycle start pulse to the crop filter.
- `cf_ap_done`  in  1  crop filter completion pulse.
- `cf_max_pixel`  in  PIXEL_BIT_WIDTH  maximum pixel reported by the crop filter; valid when `cf_ap_done` is high.
- `norm_start`  out  1  one-cycle pulse that clears the norm stage's ready flag.
- `norm_go`  out  1  one-cycle pulse that arms the norm stage; drives the norm stage's crop-done input.
- `norm_denominator`  out  PIXEL_BIT_WIDTH  registered denominator.
- `out_tvalid`  in  1  monitor of the norm stage's output valid.
- `out_tready`  in  1  monitor of the downstream ready.
- `timeout_err`  out  1  sticky watchdog flag; present only with `NORM_SEQ_WATCHDOG_EN`.

## Operation
States: IDLE, CROP_START, CROP_WAIT, NORM_RUN, DONE.
- **IDLE**
  - `ap_idle`=1.
  - On `ap_start`=1: pulse `ap_ready`, capture `frame_pixels` into `target`, pulse `norm_start`, go to CROP_START.
- **CROP_START**
  - Pulse `cf_ap_start` for one cycle, go to CROP_WAIT.
- **CROP_WAIT**
  - On `cf_ap_done`: latch `norm_denominator` = `cf_max_pixel`, or 1 if `cf_max_pixel`==0.
  - Pulse `norm_go`, clear `count`.
  - If `target`==0, go to DONE; otherwise go to NORM_RUN.
- **NORM_RUN**
  - A beat is a cycle with `out_tvalid && out_tready`. Each beat increments `count`.
  - When a beat occurs with `count`==`target`-1, go to DONE.
  - Beats arriving outside NORM_RUN are ignored and never counted.
- **DONE**
  - Pulse `ap_done` for one cycle, go to IDLE.
- `ap_start` held high re-launches one frame per pass through IDLE. `ap_start` seen outside IDLE is ignored; it is not queued.
- `frame_pixels` changes after capture have no effect on the current frame.
- Arithmetic: `count` is unsigned, PIX_CNT_WIDTH bits, and never wraps; the terminal compare stops it at `target`.

## Timing
Reset values: state=IDLE, `ap_idle`=1; `ap_done`, `ap_ready`, `cf_ap_start`, `norm_start`, `norm_go`, `timeout_err`=0; `norm_denominator`=1; `count`=0; `target`=0.
- All outputs are registered.
- `ap_ready` and `norm_start` assert in the cycle after `ap_start` is sampled high in IDLE.
- `cf_ap_start` asserts 1 cycle after `ap_ready`.
- `norm_go` and the new `norm_denominator` appear together, 1 cycle after `cf_ap_done` is sampled.
- `ap_done` asserts 1 cycle after the final beat. With `target`==0, it asserts 2 cycles after `cf_ap_done`.
- A `cf_ap_done` arriving in the same cycle as the `cf_ap_start` pulse is not seen. It is only honored in CROP_WAIT.
- Reset mid-frame: return to IDLE next cycle and drop all pulses. No `ap_done` is issued for the aborted frame.

## Configuration
`NORM_SEQ_WATCHDOG_EN`:
- **Defined**: a cycle counter runs in CROP_WAIT and NORM_RUN. It clears on entry to each state and on every beat. When it reaches `TIMEOUT_CYCLES`:
  - set `timeout_err` (sticky, cleared only by reset or a new `ap_start` acceptance);
  - go to DONE, so `ap_done` still pulses.
- **Undefined**: no counter, `timeout_err` port absent, states wait indefinitely.

## Structure
- Package `norm_pipe_pkg`:
  - state enum `seq_state_t`;
  - localparam `DENOM_ZERO_SUB` = 1.
- One sub-module is natural: `beat_counter`, a loadable terminal-count counter with a `done` output. It is instantiated once for pixel counting, and again for the watchdog when that is enabled.

## Test plan
- **Single frame**: `frame_pixels`=16, `cf_max_pixel`=200, 16 beats with ready held high.
  - `norm_denominator`=200; `ap_done` one cycle after the 16th beat; exactly one `cf_ap_start`.
- **Backpressure**: `frame_pixels`=8, `out_tready` toggles every cycle.
  - `ap_done` only after the 8th handshake; valid-without-ready cycles are not counted.
- **Zero cases**: `cf_max_pixel`=0 → `norm_denominator`=1. `frame_pixels`=0 → `ap_done` 2 cycles after `cf_ap_done`, and `norm_go` still pulses.
- **Start handling**: `ap_start` held high for 3 frames → 3 `ap_ready`/`ap_done` pairs. An `ap_start` pulse during NORM_RUN is ignored.
- **Reset mid-run**: reset after 5 of 10 beats → IDLE next cycle, `ap_done` never asserts, and the next frame counts from 0.
- **Watchdog** (`NORM_SEQ_WATCHDOG_EN`, `TIMEOUT_CYCLES`=64): `cf_ap_done` withheld → `timeout_err`=1 and `ap_done` pulse after 64 cycles in CROP_WAIT.

Source files
------------

// File: rtl/norm_pipeline_sequencer_pkg.sv
// Shared types for the crop/normalization frame sequencer.
package norm_pipe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CROP_START,
    CROP_WAIT,
    NORM_RUN,
    DONE
  } seq_state_t;

  // Substitute denominator when the crop filter reports an all-black frame.
  localparam int DENOM_ZERO_SUB = 1;

endpackage

// File: rtl/norm_pipeline_sequencer_beat_counter.sv
// Terminal-count counter: clears on demand, counts enabled cycles, saturates at
// the loaded terminal value and flags the cycle that reaches it.
module beat_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_inc;

  assign count_inc = count_reg + 1'b1;
  assign done      = en && !clear && (count_inc == terminal);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en && (count_reg != terminal)) begin
      count_reg <= count_inc;
    end
  end

endmodule

// File: rtl/norm_pipeline_sequencer.sv
// Frame sequencer: launches the crop filter, arms the norm stage and counts
// accepted output pixels. Optional watchdog via NORM_SEQ_WATCHDOG_EN.
module norm_pipeline_sequencer
  import norm_pipe_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int PIX_CNT_WIDTH   = 20,
  parameter int TIMEOUT_CYCLES  = 1048576
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  output logic                       ap_ready,
  input  logic [PIX_CNT_WIDTH-1:0]   frame_pixels,
  output logic                       cf_ap_start,
  input  logic                       cf_ap_done,
  input  logic [PIXEL_BIT_WIDTH-1:0] cf_max_pixel,
  output logic                       norm_start,
  output logic                       norm_go,
  output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
  input  logic                       out_tvalid,
  input  logic                       out_tready
`ifdef NORM_SEQ_WATCHDOG_EN
  ,
  output logic                       timeout_err
`endif
);

  seq_state_t                 state_reg, state_next;
  logic [PIX_CNT_WIDTH-1:0]   target_reg, target_next;
  logic [PIXEL_BIT_WIDTH-1:0] denom_reg, denom_next;
  logic ap_done_reg, ap_done_next;
  logic ap_idle_reg, ap_idle_next;
  logic ap_ready_reg, ap_ready_next;
  logic cf_ap_start_reg, cf_ap_start_next;
  logic norm_start_reg, norm_start_next;
  logic norm_go_reg, norm_go_next;

  logic beat;
  logic crop_done;
  logic pix_last;
  logic wd_expire;

  assign beat = out_tvalid && out_tready && (state_reg == NORM_RUN);
  // The cycle carrying the cf_ap_start pulse is blind to cf_ap_done.
  assign crop_done = (state_reg == CROP_WAIT) && cf_ap_done && !cf_ap_start_reg;

  beat_counter #(.WIDTH(PIX_CNT_WIDTH)) u_pix_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (crop_done),
    .en       (beat),
    .terminal (target_reg),
    .done     (pix_last)
  );

`ifdef NORM_SEQ_WATCHDOG_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic wd_clear;
  logic wd_en;
  logic timeout_err_reg;

  assign wd_clear = (state_reg == CROP_START) || crop_done || beat;
  assign wd_en    = (state_reg == CROP_WAIT) || (state_reg == NORM_RUN);

  beat_counter #(.WIDTH(WD_WIDTH)) u_wd_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .en       (wd_en),
    .terminal (WD_WIDTH'(TIMEOUT_CYCLES)),
    .done     (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_reg <= 1'b0;
    end else if ((state_reg == IDLE) && ap_start) begin
      timeout_err_reg <= 1'b0;
    end else if (wd_expire) begin
      timeout_err_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    target_next      = target_reg;
    denom_next       = denom_reg;
    ap_done_next     = 1'b0;
    ap_ready_next    = 1'b0;
    cf_ap_start_next = 1'b0;
    norm_start_next  = 1'b0;
    norm_go_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ap_start) begin
          ap_ready_next   = 1'b1;
          norm_start_next = 1'b1;
          target_next     = frame_pixels;
          state_next      = CROP_START;
        end
      end
      CROP_START: begin
        cf_ap_start_next = 1'b1;
        state_next       = CROP_WAIT;
      end
      CROP_WAIT: begin
        if (crop_done) begin
          denom_next   = (cf_max_pixel == '0) ? PIXEL_BIT_WIDTH'(DENOM_ZERO_SUB) : cf_max_pixel;
          norm_go_next = 1'b1;
          state_next   = (target_reg == '0) ? DONE : NORM_RUN;
        end else if (wd_expire) begin
          state_next = DONE;
        end
      end
      NORM_RUN: begin
        // Final beat raises ap_done directly so it lands one cycle after the beat.
        if (pix_last) begin
          ap_done_next = 1'b1;
          state_next   = DONE;
        end else if (wd_expire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ap_done_next = !ap_done_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    ap_idle_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      target_reg      <= '0;
      denom_reg       <= PIXEL_BIT_WIDTH'(DENOM_ZERO_SUB);
      ap_done_reg     <= 1'b0;
      ap_idle_reg     <= 1'b1;
      ap_ready_reg    <= 1'b0;
      cf_ap_start_reg <= 1'b0;
      norm_start_reg  <= 1'b0;
      norm_go_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      target_reg      <= target_next;
      denom_reg       <= denom_next;
      ap_done_reg     <= ap_done_next;
      ap_idle_reg     <= ap_idle_next;
      ap_ready_reg    <= ap_ready_next;
      cf_ap_start_reg <= cf_ap_start_next;
      norm_start_reg  <= norm_start_next;
      norm_go_reg     <= norm_go_next;
    end
  end

  assign ap_done          = ap_done_reg;
  assign ap_idle          = ap_idle_reg;
  assign ap_ready         = ap_ready_reg;
  assign cf_ap_start      = cf_ap_start_reg;
  assign norm_start       = norm_start_reg;
  assign norm_go          = norm_go_reg;
  assign norm_denominator = denom_reg;

endmodule

// File: tb/tb_norm_pipeline_sequencer.sv
// Scoreboard bench for norm_pipeline_sequencer: stimulus queues expected pulses
// and level samples with their cycle numbers; a negedge monitor checks them.
module tb_norm_pipeline_sequencer;

  logic        clk;
  logic        reset;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [19:0] frame_pixels;
  logic        cf_ap_start;
  logic        cf_ap_done;
  logic [9:0]  cf_max_pixel;
  logic        norm_start;
  logic        norm_go;
  logic [9:0]  norm_denominator;
  logic        out_tvalid;
  logic        out_tready;
`ifdef NORM_SEQ_WATCHDOG_EN
  logic        timeout_err;
`endif

  norm_pipeline_sequencer #(
    .PIXEL_BIT_WIDTH (10),
    .PIX_CNT_WIDTH   (20),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .frame_pixels     (frame_pixels),
    .cf_ap_start      (cf_ap_start),
    .cf_ap_done       (cf_ap_done),
    .cf_max_pixel     (cf_max_pixel),
    .norm_start       (norm_start),
    .norm_go          (norm_go),
    .norm_denominator (norm_denominator),
    .out_tvalid       (out_tvalid),
    .out_tready       (out_tready)
`ifdef NORM_SEQ_WATCHDOG_EN
    ,
    .timeout_err      (timeout_err)
`endif
  );

  typedef enum int {EV_READY, EV_NSTART, EV_CFSTART, EV_NGO, EV_DONE} ev_kind_t;
  typedef enum int {L_IDLE, L_DENOM, L_TERR} lvl_kind_t;
  typedef struct {ev_kind_t kind; int cyc; int val;} ev_t;
  typedef struct {lvl_kind_t kind; int cyc; int val;} lvl_t;

  ev_t  ev_q[$];
  lvl_t lvl_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(ev_kind_t k);
    case (k)
      EV_READY:   return "ap_ready";
      EV_NSTART:  return "norm_start";
      EV_CFSTART: return "cf_ap_start";
      EV_NGO:     return "norm_go";
      default:    return "ap_done";
    endcase
  endfunction

  function automatic string lvl_name(lvl_kind_t k);
    case (k)
      L_IDLE:  return "ap_idle";
      L_DENOM: return "norm_denominator";
      default: return "timeout_err";
    endcase
  endfunction

  function automatic int lvl_value(lvl_kind_t k);
    case (k)
      L_IDLE:  return int'(ap_idle);
      L_DENOM: return int'(norm_denominator);
`ifdef NORM_SEQ_WATCHDOG_EN
      default: return int'(timeout_err);
`else
      default: return 0;
`endif
    endcase
  endfunction

  task automatic push_ev(input ev_kind_t k, input int c, input int v);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v;
    ev_q.push_back(e);
  endtask

  task automatic push_lvl(input lvl_kind_t k, input int c, input int v);
    lvl_t l;
    l.kind = k; l.cyc = c; l.val = v;
    lvl_q.push_back(l);
  endtask

  task automatic check_pulse(input ev_kind_t k, input logic sig, input int c);
    ev_t e;
    if (sig === 1'b1) begin
      tests++;
      if (ev_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_%s cyc=%0d got=pulse expected=none", ev_name(k), c);
      end else if (ev_q[0].kind != k) begin
        fails++;
        $display("FAIL unexpected_%s cyc=%0d got=pulse expected=%s@%0d",
                 ev_name(k), c, ev_name(ev_q[0].kind), ev_q[0].cyc);
      end else begin
        e = ev_q.pop_front();
        if (e.cyc != c || (k == EV_NGO && e.val != int'(norm_denominator))) begin
          fails++;
          $display("FAIL %s cyc=%0d got_denom=%0d expected_cyc=%0d expected_denom=%0d",
                   ev_name(k), c, norm_denominator, e.cyc, e.val);
        end else begin
          $display("[TB] ok %s cyc=%0d denom=%0d", ev_name(k), c, norm_denominator);
        end
      end
    end
  endtask

  // Monitor: sole owner of the test/fail counters.
  initial begin
    int   c;
    lvl_t l;
    int   act;
    forever begin
      @(negedge clk);
      c = cyc;
      while (ev_q.size() > 0 && ev_q[0].cyc < c) begin
        tests++;
        fails++;
        $display("FAIL missing_%s cyc=%0d got=none expected_at=%0d",
                 ev_name(ev_q[0].kind), c, ev_q[0].cyc);
        void'(ev_q.pop_front());
      end
      check_pulse(EV_READY,   ap_ready,    c);
      check_pulse(EV_NSTART,  norm_start,  c);
      check_pulse(EV_CFSTART, cf_ap_start, c);
      check_pulse(EV_NGO,     norm_go,     c);
      check_pulse(EV_DONE,    ap_done,     c);
      while (lvl_q.size() > 0 && lvl_q[0].cyc <= c) begin
        l = lvl_q.pop_front();
        act = lvl_value(l.kind);
        tests++;
        if (l.cyc != c || act != l.val) begin
          fails++;
          $display("FAIL level_%s cyc=%0d got=%0d expected=%0d@%0d",
                   lvl_name(l.kind), c, act, l.val, l.cyc);
        end else begin
          $display("[TB] ok %s cyc=%0d value=%0d", lvl_name(l.kind), c, act);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame; toggle = ready alternates, glitch = beat index carrying a stray
  // ap_start, abort_at = beats before a mid-run reset, early = cf_ap_done
  // coincident with the cf_ap_start pulse.
  task automatic frame(input int fp, input int maxpix, input bit toggle, input int crop_delay,
                       input bit hold, input int glitch, input int abort_at, input bit early);
    int s, d, beats, i, expd;
    s = cyc;
    frame_pixels = 20'(fp);
    ap_start = 1'b1;
    push_ev(EV_READY, s + 1, 0);
    push_ev(EV_NSTART, s + 1, 0);
    push_ev(EV_CFSTART, s + 2, 0);
    push_lvl(L_IDLE, s + 2, 0);
    tick();
    if (!hold) ap_start = 1'b0;
    frame_pixels = 20'(fp + 7);
    tick();
    if (early) begin
      cf_ap_done = 1'b1;
      cf_max_pixel = 10'd7;
    end
    repeat (crop_delay) begin
      tick();
      cf_ap_done = 1'b0;
    end
    expd = (maxpix == 0) ? 1 : maxpix;
    cf_ap_done = 1'b1;
    cf_max_pixel = 10'(maxpix);
    d = cyc + 1;
    push_ev(EV_NGO, d, expd);
    push_lvl(L_DENOM, d, expd);
    if (fp == 0) push_ev(EV_DONE, d + 1, 0);
    tick();
    cf_ap_done = 1'b0;
    cf_max_pixel = 10'd3;
    beats = 0;
    i = 0;
    while (beats < fp && i < 4 * fp + 8) begin
      if (abort_at >= 0 && beats == abort_at) begin
        reset = 1'b1;
        out_tvalid = 1'b0;
        out_tready = 1'b0;
        ap_start = 1'b0;
        tick();
        reset = 1'b0;
        push_lvl(L_IDLE, cyc, 1);
        push_lvl(L_DENOM, cyc, 1);
        return;
      end
      out_tvalid = 1'b1;
      out_tready = toggle ? i[0] : 1'b1;
      if (glitch >= 0) ap_start = (i == glitch) ? 1'b1 : hold;
      if (out_tready && beats == fp - 1) push_ev(EV_DONE, cyc + 1, 0);
      tick();
      if (out_tready) beats++;
      i++;
    end
    out_tvalid = 1'b0;
    out_tready = 1'b0;
    if (glitch >= 0) ap_start = hold;
    tick();
    push_lvl(L_IDLE, cyc, 1);
  endtask

  initial begin
    reset = 1'b1;
    ap_start = 1'b0;
    frame_pixels = '0;
    cf_ap_done = 1'b0;
    cf_max_pixel = '0;
    out_tvalid = 1'b0;
    out_tready = 1'b0;
    repeat (3) tick();
    push_lvl(L_IDLE, cyc, 1);
    push_lvl(L_DENOM, cyc, 1);
    push_lvl(L_TERR, cyc, 0);
    reset = 1'b0;
    tick();

    frame(16, 200, 1'b0, 3, 1'b0, -1, -1, 1'b0);   // single frame
    repeat (2) tick();
    frame(8, 513, 1'b1, 1, 1'b0, -1, -1, 1'b1);    // backpressure, early cf_ap_done
    repeat (2) tick();
    frame(0, 0, 1'b0, 2, 1'b0, -1, -1, 1'b0);      // zero target and zero max
    repeat (3) tick();
    frame(3, 5, 1'b0, 1, 1'b1, -1, -1, 1'b0);      // ap_start held for three frames
    frame(2, 6, 1'b1, 2, 1'b1, -1, -1, 1'b0);
    frame(4, 1023, 1'b0, 1, 1'b0, -1, -1, 1'b0);
    repeat (2) tick();
    frame(6, 300, 1'b0, 2, 1'b0, 2, -1, 1'b0);     // stray ap_start in NORM_RUN
    repeat (2) tick();
    frame(10, 50, 1'b0, 2, 1'b0, -1, 5, 1'b0);     // reset after 5 of 10 beats
    repeat (2) tick();
    frame(10, 60, 1'b0, 2, 1'b0, -1, -1, 1'b0);

`ifdef NORM_SEQ_WATCHDOG_EN
    begin
      int s;
      repeat (2) tick();
      s = cyc;
      frame_pixels = 20'd4;
      ap_start = 1'b1;
      push_ev(EV_READY, s + 1, 0);
      push_ev(EV_NSTART, s + 1, 0);
      push_ev(EV_CFSTART, s + 2, 0);
      push_lvl(L_IDLE, s + 2, 0);
      push_lvl(L_TERR, s + 65, 0);
      push_lvl(L_TERR, s + 66, 1);
      push_ev(EV_DONE, s + 67, 0);
      push_lvl(L_IDLE, s + 67, 1);
      tick();
      ap_start = 1'b0;
      repeat (67) tick();
      push_lvl(L_TERR, cyc, 1);
      push_lvl(L_TERR, cyc + 1, 0);
      frame(0, 12, 1'b0, 1, 1'b0, -1, -1, 1'b0);
    end
`endif

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
